// File: rtl/p2m_demux_pkg.sv
// Shared constants, sizing helper and drop-status record for the pipe-to-method demux FIFO.
package p2m_demux_pkg;

  localparam int ID_WIDTH_DEFAULT   = 16;
  localparam int DROP_COUNT_WIDTH   = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // drop_id storage is sized to the default ID width; wider IDs are truncated.
  typedef struct packed {
    logic                        err;
    logic [DROP_COUNT_WIDTH-1:0] count;
    logic [ID_WIDTH_DEFAULT-1:0] id;
  } drop_status_t;

endpackage

// File: rtl/p2m_chan_fifo.sv
// Single-clock per-channel FIFO: enq/deq handshakes, combinational head read, registered occupancy.
module p2m_chan_fifo
  import p2m_demux_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_ena,
  input  logic [WIDTH-1:0] enq_data,
  output logic             enq_rdy,
  input  logic             deq_ena,
  output logic             deq_rdy,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             do_enq;
  logic             do_deq;

  // Full comes from the registered count only, so a same-cycle dequeue never frees a slot early.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign enq_rdy   = !full;
  assign deq_rdy   = !empty;
  assign do_enq    = enq_ena && !full;
  assign do_deq    = deq_ena && !empty;
  assign head_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_enq) mem[wptr] <= enq_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_enq) wptr <= wptr + 1'b1;
      if (do_deq) rptr <= rptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/p2m_demux_fifo.sv
// Routes packed pipe words {id, payload} to per-method FIFOs; unknown IDs are dropped and counted.
module p2m_demux_fifo
  import p2m_demux_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int ID_WIDTH = ID_WIDTH_DEFAULT,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         pipe_enq__ENA,
  input  logic [ID_WIDTH+WIDTH-1:0]    pipe_enq_v,
  output logic                         pipe_enq__RDY,
  output logic [CHANNELS-1:0]          method__ENA,
  output logic [CHANNELS*WIDTH-1:0]    method_v,
  input  logic [CHANNELS-1:0]          method__RDY,
  input  logic                         drop_clear__ENA,
  output logic [DROP_COUNT_WIDTH-1:0]  drop_count,
  output logic                         drop_err,
  output logic [ID_WIDTH-1:0]          drop_id
);

  logic [ID_WIDTH-1:0] pipe_id;
  logic [WIDTH-1:0]    pipe_payload;
  logic                id_valid;
  logic                target_rdy;
  logic                accept;
  logic                drop;
  logic [CHANNELS-1:0] chan_enq_rdy;
  logic [CHANNELS-1:0] chan_enq;
  drop_status_t        drop_q;

  assign pipe_id      = pipe_enq_v[ID_WIDTH+WIDTH-1 -: ID_WIDTH];
  assign pipe_payload = pipe_enq_v[WIDTH-1:0];
  assign id_valid     = (32'(pipe_id) < 32'(CHANNELS));

  always_comb begin
    target_rdy = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (32'(pipe_id) == 32'(c)) target_rdy = chan_enq_rdy[c];
    end
  end

  // Unknown IDs are always accepted so a bad word can never stall the pipe.
  assign pipe_enq__RDY = !id_valid || target_rdy;
  assign accept        = pipe_enq__ENA && pipe_enq__RDY;
  assign drop          = accept && !id_valid;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign chan_enq[c] = accept && (32'(pipe_id) == 32'(c));

    p2m_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (CLK),
      .rst_n     (nRST),
      .enq_ena   (chan_enq[c]),
      .enq_data  (pipe_payload),
      .enq_rdy   (chan_enq_rdy[c]),
      .deq_ena   (method__RDY[c]),
      .deq_rdy   (method__ENA[c]),
      .head_data (method_v[c*WIDTH +: WIDTH])
    );
  end

  // A clear coinciding with a drop wins for count/err, but the new id is still captured.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      drop_q <= '0;
    end else begin
      if (drop_clear__ENA) begin
        drop_q.err   <= 1'b0;
        drop_q.count <= '0;
        drop_q.id    <= '0;
      end
      if (drop) begin
        drop_q.id <= ID_WIDTH_DEFAULT'(pipe_id);
        if (!drop_clear__ENA) begin
          drop_q.err <= 1'b1;
          if (drop_q.count != '1) drop_q.count <= drop_q.count + 1'b1;
        end
      end
    end
  end

  assign drop_count = drop_q.count;
  assign drop_err   = drop_q.err;
  assign drop_id    = ID_WIDTH'(drop_q.id);

endmodule

// File: doc/p2m_demux_fifo.md
Name: p2m_demux_fifo

Overview:
- Parametrised successor of the single-method pipe-to-method adapter.
- Accepts a packed pipe word (method ID in the top ID_WIDTH bits, payload below) and routes it to one of CHANNELS method outputs.
- Each method output is buffered by its own DEPTH-entry FIFO.
- Unknown method IDs are consumed, dropped and counted; they never stall the pipe.
- Sits between the host-side pipe and the DUT's request interfaces in the top-level wrapper.

Parameters:
- WIDTH, 128, payload bits per method call.
- ID_WIDTH, 16, method-ID field width.
- CHANNELS, 4, number of method outputs (1..16).
- DEPTH, 4, entries per channel FIFO (power of two, >=2).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- pipe$enq__ENA  in  1  pipe word valid/enable.
- pipe$enq$v  in  ID_WIDTH+WIDTH  {id, payload}; id = v[ID_WIDTH+WIDTH-1 -: ID_WIDTH].
- pipe$enq__RDY  out  1  pipe may enqueue.
- method$__ENA  out  CHANNELS  per-channel call valid.
- method$v  out  CHANNELS*WIDTH  per-channel payload; channel c occupies [c*WIDTH +: WIDTH].
- method$__RDY  in  CHANNELS  per-channel sink ready.
- drop_clear__ENA  in  1  clear drop counter and error flag.
- drop_count  out  16  number of dropped words, saturating.
- drop_err  out  1  sticky: at least one word dropped since reset/clear.
- drop_id  out  ID_WIDTH  ID of the most recent dropped word.

Behaviour:
- Reset (nRST low, asynchronous): all FIFOs empty, pointers 0.
  - method$__ENA = 0, drop_count = 0, drop_err = 0, drop_id = 0.
  - pipe$enq__RDY = 1 whenever nRST is high and the target condition holds.
- Guard: pipe$enq__RDY = (id >= CHANNELS) || !full[id]. The guard depends on the data, consistent with existing adapter guards.
- Accept: a transfer occurs when pipe$enq__ENA && pipe$enq__RDY. pipe$enq__ENA while RDY = 0 is a protocol error; the word is ignored with no state change.
- Valid ID (id < CHANNELS): payload is written at wptr[id], wptr increments modulo DEPTH, count[id] increments.
- Invalid ID: no FIFO write.
  - drop_count += 1, saturating at 16'hFFFF.
  - drop_err <= 1.
  - drop_id <= id.
- Output channel c:
  - method$__ENA[c] = (count[c] != 0).
  - method$v slice c = mem[c][rptr[c]], read combinationally from storage.
  - Fire when ENA[c] && RDY[c]: rptr increments modulo DEPTH, count decrements.
- Latency: a word accepted in cycle N appears on method$__ENA in cycle N+1. There is no combinational enq-to-method path.
- Full FIFO: RDY is derived from registered full only, so a full channel does not accept even if it dequeues in the same cycle. This is a deliberate no-bypass choice that breaks the RDY/RDY combinational loop.
- Simultaneous enq and deq on a non-full, non-empty channel: count unchanged, both pointers advance.
- Simultaneous enq and deq on an empty channel: not possible, because ENA is 0 while empty.
- Channels are fully independent; one channel's back-pressure blocks the pipe only while the word at the head of the pipe targets that channel (head-of-line blocking is accepted).
- drop_clear__ENA:
  - Resets drop_count, drop_err and drop_id to 0.
  - If it coincides with a drop, the clear wins for drop_count and drop_err, then the drop is not counted.
  - drop_id still captures the new id.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full = (count == DEPTH); count is log2(DEPTH)+1 bits.
- Reset mid-operation: all queued words are discarded immediately; outputs return to reset values asynchronously.

Decomposition:
- Package p2m_demux_pkg:
  - ID_WIDTH default constant.
  - Function clog2 for pointer/count sizing.
  - Typedef for the drop status struct {err, count, id}.
- Sub-module p2m_chan_fifo(WIDTH, DEPTH):
  - Single-clock FIFO with enq/deq ENA/RDY, head data, and count/full/empty.
  - Instantiated CHANNELS times by generate.
- The top level holds only the ID decode, guard mux and drop logic.

Test Plan:
1. Reset, then enq {id=2, payload=0xA5}: RDY=1 and the word is accepted; the next cycle method$__ENA=4'b0100 with slice 2 = 0xA5. Fire with RDY[2]=1, then ENA=0.
2. Hold method$__RDY[1]=0 and enq 4 words to id=1 (payloads 1..4): all are accepted, then RDY drops for id=1 while an id=0 word is still accepted. Release RDY[1]: outputs 1,2,3,4 in order, and the 5th id=1 word is accepted only after the first deq.
3. Enq id=7 and then id=0xFFFF with CHANNELS=4: both are accepted with no method ENA; drop_count=2, drop_err=1, drop_id=0xFFFF.
4. Full channel 3 with RDY[3]=1 in the same cycle as a new id=3 word: the deq happens and the enq is refused. The word is accepted the following cycle and appears after three older entries.
5. Force drop_count to 0xFFFF via repeated bad IDs: it stays at 0xFFFF. drop_clear__ENA coinciding with a bad id=5 gives count=0, err=0, drop_id=5.
6. Queue 2 words on each channel, then pulse nRST low asynchronously mid-cycle: all method$__ENA=0 and drop status is 0 immediately. After release, a new id=0 word emerges alone.
